alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares a single combinational add/sub/shift ALU between two independent requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- A 3-state FSM serialises operations: accept, then execute one cycle through the ALU, then hold the response.
- Arbitration is round-robin. Sits between the two client units and the one shared ALU instance.

Parameters:
WIDTH, 32, operand/result width; must match the ALU data width.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has an operation pending
req0_ready  output  1  arbiter accepts requester 0 operation this cycle
req0_a  input  WIDTH  requester 0 operand A
req0_b  input  WIDTH  requester 0 operand B
req0_op  input  2  requester 0 opcode (00 add, 01 sub, 10 shl, 11 shr)
rsp0_valid  output  1  result for requester 0 available
rsp0_ready  input  1  requester 0 takes the result
rsp0_result  output  WIDTH  result for requester 0
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
rsp1_valid, rsp1_ready, rsp1_result  same as requester 0, for requester 1
alu_a  output  WIDTH  operand A driven to shared ALU
alu_b  output  WIDTH  operand B driven to shared ALU
alu_opcode  output  2  opcode driven to shared ALU
alu_result  input  WIDTH  combinational result from shared ALU
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst high at a clk edge), next-cycle values:
  - state=IDLE; last_grant=1, so requester 0 wins the first tie.
  - Operand/opcode latches = 0; result register = 0.
  - All valid/ready outputs 0; busy=0; rsp0_result=rsp1_result=0.
  - rst mid-operation aborts the in-flight op; no response is ever issued for it.
- States:
  - IDLE:
    - Grant requester 0 if only req0_valid is high; grant requester 1 if only req1_valid is high.
    - If both are high, grant the requester NOT equal to last_grant.
    - reqN_ready = (state==IDLE) && grant==N (combinational; at most one ready high).
    - On handshake (reqN_valid && reqN_ready): latch a/b/op and owner=N; set last_grant=N; go to EXEC.
    - No valid requester: stay in IDLE.
  - EXEC (exactly one cycle):
    - alu_a/alu_b/alu_opcode driven from the latches.
    - alu_result captured into the result register at the edge; go to RESP.
  - RESP:
    - rsp<owner>_valid=1; rsp<owner>_result=result register.
    - The other rsp valid stays 0.
    - Hold until rsp<owner>_ready is high at an edge, then go to IDLE.
    - A new request is not accepted in the same cycle as the response handshake.
- ALU drive outside EXEC: alu_a/alu_b/alu_opcode show the latched values at all times (stable, no glitch-driven muxing).
- Latency: request accepted at edge T gives rsp_valid high from cycle T+2. Minimum spacing between accepts is 3 cycles.
- Arithmetic: the arbiter does no arithmetic of its own; results are exactly as returned by the ALU.
  - Add/sub wrap modulo 2^WIDTH.
  - Shift amount is the full B value; B >= WIDTH yields 0.
- rspN_result holds its last value after the handshake; only its valid drops.
- Request channel: operand inputs are sampled only on the handshake cycle. A requester may deassert valid before being granted with no effect.
- rspN_ready asserted while rspN_valid is low is ignored.

Test Plan:
- Reset then single op: req0 a=5, b=3, op=00 -> req0_ready same cycle; rsp0_valid 2 cycles later with result 8; busy high for 2 cycles then until response taken.
- Subtract wrap: req1 a=0, b=1, op=01 -> rsp1_result=0xFFFFFFFF; rsp0_valid stays 0 throughout.
- Shifts: req0 a=1, b=31, op=10 -> 0x80000000; req0 a=0x80000000, b=32, op=11 -> 0.
- Contention: both valid every cycle from reset, four ops -> grants in order 0,1,0,1; each response routed to the correct requester with its own operands.
- Backpressure: rsp0_ready held low 5 cycles -> rsp0_valid and result stable, req1_ready stays 0; when rsp0_ready rises, the FSM returns to IDLE next cycle and req1 is then granted.
- Reset mid-op: rst asserted during EXEC -> next cycle IDLE, all valids 0, no response issued; the next req0 is granted first.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin sharing of one combinational ALU between two
//            valid/ready requesters; accept -> execute -> respond.
// Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
  logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;

  logic             grant_vld;
  logic             grant_id;
  logic             rsp_taken;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    grant_vld = req0_valid || req1_valid;
    grant_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    rsp_taken = owner_q ? rsp1_ready : rsp0_ready;
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    rsp0_result_d = rsp0_result_q;
    rsp1_result_d = rsp1_result_q;
    rsp0_valid_d  = rsp0_valid_q;
    rsp1_valid_d  = rsp1_valid_q;

    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          a_d          = grant_id ? req1_a  : req0_a;
          b_d          = grant_id ? req1_b  : req0_b;
          op_d         = grant_id ? req1_op : req0_op;
          owner_d      = grant_id;
          last_grant_d = grant_id;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        if (owner_q) begin
          rsp1_result_d = alu_result;
          rsp1_valid_d  = 1'b1;
        end else begin
          rsp0_result_d = alu_result;
          rsp0_valid_d  = 1'b1;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_taken) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= 2'd0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
    end
  end

  // ALU operands come straight from the latches so they never glitch.
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_opcode  = op_q;

  assign req0_ready  = (state_q == S_IDLE) && grant_vld && !grant_id;
  assign req1_ready  = (state_q == S_IDLE) && grant_vld &&  grant_id;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp1_result = rsp1_result_q;
  assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed bench for alu_arbiter with a reference ALU and
//            per-requester expected-result queues.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]       req0_op, req1_op;
  logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp0_result, rsp1_result;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [1:0]       alu_opcode;
  logic             busy;

  int n_pass  = 0;
  int n_total = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  int               grants[$];

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a, b,
                                             input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return (b >= WIDTH) ? '0 : (a << b);
      default: return (b >= WIDTH) ? '0 : (a >> b);
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_opcode);

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .busy(busy)
  );

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Scoreboard: expected results pushed at request handshake, popped at response.
  always @(posedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      chk("rsp_onehot", {31'd0, rsp0_valid && rsp1_valid}, 0);
      chk("rsp0_spurious", {31'd0, rsp0_valid && (q0.size() == 0)}, 0);
      chk("rsp1_spurious", {31'd0, rsp1_valid && (q1.size() == 0)}, 0);
      if (req0_valid && req0_ready) begin
        q0.push_back(alu_f(req0_a, req0_b, req0_op));
        grants.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        q1.push_back(alu_f(req1_a, req1_b, req1_op));
        grants.push_back(1);
      end
      if (rsp0_valid && rsp0_ready && q0.size() > 0)
        chk("rsp0_result", rsp0_result, q0.pop_front());
      if (rsp1_valid && rsp1_ready && q1.size() > 0)
        chk("rsp1_result", rsp1_result, q1.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit r, input logic [WIDTH-1:0] a, b,
                       input logic [1:0] op);
    logic got;
    got = 1'b0;
    if (r) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    for (int i = 0; i < 20; i++) begin
      #1;
      if (r ? req1_ready : req0_ready) begin got = 1'b1; break; end
      tick();
    end
    chk("issue_grant", {31'd0, got}, 1);
    tick();
    if (r) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(input bit r);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (r ? rsp1_valid : rsp0_valid) begin got = 1'b1; break; end
      tick();
    end
    chk("rsp_wait", {31'd0, got}, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    do_reset();

    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 0);
    chk("rst_rsp0_result", rsp0_result, 0);
    chk("rst_rsp1_result", rsp1_result, 0);
    chk("rst_req_ready", {30'd0, req1_ready, req0_ready}, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", {30'd0, alu_opcode}, 0);

    // Single add with latency and busy profile.
    req0_valid = 1; req0_a = 5; req0_b = 3; req0_op = 0;
    #1;
    chk("add_req0_ready", {31'd0, req0_ready}, 1);
    chk("add_req1_ready", {31'd0, req1_ready}, 0);
    tick();
    req0_valid = 0;
    chk("add_exec_busy", {31'd0, busy}, 1);
    chk("add_exec_valid", {31'd0, rsp0_valid}, 0);
    chk("add_alu_a", alu_a, 5);
    chk("add_alu_b", alu_b, 3);
    tick();
    chk("add_resp_valid", {31'd0, rsp0_valid}, 1);
    chk("add_resp_result", rsp0_result, 8);
    chk("add_resp_busy", {31'd0, busy}, 1);
    tick();
    chk("add_done_busy", {31'd0, busy}, 0);
    chk("add_done_valid", {31'd0, rsp0_valid}, 0);
    chk("add_hold_result", rsp0_result, 8);

    // Subtract wrap on requester 1.
    issue(1, 0, 1, 1);
    wait_rsp(1);
    chk("sub_wrap", rsp1_result, 32'hFFFF_FFFF);
    chk("sub_rsp0_quiet", {31'd0, rsp0_valid}, 0);
    tick();

    // Shift boundaries.
    issue(0, 1, 31, 2);
    wait_rsp(0);
    chk("shl_31", rsp0_result, 32'h8000_0000);
    tick();
    issue(0, 32'h8000_0000, 32, 3);
    wait_rsp(0);
    chk("shr_32", rsp0_result, 0);
    tick();

    // Contention from reset: both always valid, operands change each cycle.
    do_reset();
    grants.delete();
    req0_valid = 1; req0_op = 0; req0_b = 7;
    req1_valid = 1; req1_op = 1; req1_b = 8;
    for (int i = 0; i < 40 && grants.size() < 4; i++) begin
      req0_a = 32'(i * 3);
      req1_a = 32'(1000 + i);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("cont_grants", grants.size(), 4);
    if (grants.size() >= 4) begin
      chk("cont_g0", grants[0], 0);
      chk("cont_g1", grants[1], 1);
      chk("cont_g2", grants[2], 0);
      chk("cont_g3", grants[3], 1);
    end
    tick();
    chk("cont_drained", q0.size() + q1.size(), 0);

    // Backpressure on requester 0 while requester 1 waits.
    rsp0_ready = 0;
    issue(0, 7, 9, 0);
    req1_valid = 1; req1_a = 2; req1_b = 2; req1_op = 0;
    wait_rsp(0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, rsp0_valid}, 1);
      chk("bp_result", rsp0_result, 16);
      chk("bp_req1_ready", {31'd0, req1_ready}, 0);
      tick();
    end
    rsp0_ready = 1;
    tick();
    chk("bp_idle", {31'd0, busy}, 0);
    chk("bp_req1_grant", {31'd0, req1_ready}, 1);
    tick();
    req1_valid = 0;
    wait_rsp(1);
    chk("bp_req1_result", rsp1_result, 4);
    tick();

    // Reset during EXEC aborts the op; requester 0 then wins the tie.
    issue(0, 11, 22, 0);
    chk("abort_in_exec", {31'd0, busy}, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_valids", {30'd0, rsp1_valid, rsp0_valid}, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("abort_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 0);
    req0_valid = 1; req0_a = 4; req0_b = 4; req0_op = 1;
    req1_valid = 1; req1_a = 9; req1_b = 9; req1_op = 0;
    #1;
    chk("post_rst_req0_first", {30'd0, req1_ready, req0_ready}, 1);
    tick();
    req0_valid = 0; req1_valid = 0;
    wait_rsp(0);
    chk("post_rst_result", rsp0_result, 0);
    tick();
    tick();
    chk("final_drained", q0.size() + q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
